// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 set-2 key event generator.
// State codes, prefix/reply byte values and the ps2_key field layout.
package ps2_key_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PFX_E0   = 3'd1;
   localparam logic [2:0] ST_PFX_F0   = 3'd2;
   localparam logic [2:0] ST_PFX_E0F0 = 3'd3;
   localparam logic [2:0] ST_SKIP     = 3'd4;

   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_E1 = 8'hE1;
   localparam logic [7:0] BYTE_12 = 8'h12;
   localparam logic [7:0] BYTE_59 = 8'h59;

   // Keyboard protocol replies (ack, resend, BAT result, echo, errors).
   localparam int NUM_REPLY = 8;
   localparam logic [NUM_REPLY-1:0][7:0] REPLY_LIST =
      {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

   localparam int KEY_TOGGLE   = 10;
   localparam int KEY_PRESSED  = 9;
   localparam int KEY_EXTENDED = 8;
   localparam int KEY_CODE_MSB = 7;

   typedef struct packed {
      logic       toggle;
      logic       pressed;
      logic       extended;
      logic [7:0] code;
   } ps2_key_t;

   function automatic logic is_reply(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_REPLY; i++)
         if (b == REPLY_LIST[i]) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == BYTE_E0) || (b == BYTE_F0) || (b == BYTE_E1);
   endfunction

   function automatic logic is_fake_shift(input logic [7:0] b);
      return (b == BYTE_12) || (b == BYTE_59);
   endfunction

endpackage

// File: rtl/ps2_held_map.sv
// 512x1 held-key bitmap indexed by {extended, code}; sweeps itself clear
// after reset (busy high meanwhile) and offers a same-cycle read with write.
module ps2_held_map (
   input  logic       clk_sys,
   input  logic       reset_l,
   input  logic [8:0] addr,
   input  logic       wr_en,
   input  logic       wr_data,
   output logic       held,
   output logic       busy
);

   logic [511:0] map_q;
   logic [8:0]   clr_idx;

   always_ff @(posedge clk_sys or negedge reset_l) begin
      if (!reset_l) begin
         busy    <= 1'b1;
         clr_idx <= '0;
      end else if (busy) begin
         clr_idx <= clr_idx + 9'd1;
         if (clr_idx == 9'h1FF) busy <= 1'b0;
      end
   end

   // Storage carries no reset; the sweep owns it until busy drops.
   always_ff @(posedge clk_sys) begin
      if (busy)       map_q[clr_idx] <= 1'b0;
      else if (wr_en) map_q[addr]    <= wr_data;
   end

   assign held = map_q[addr];

endmodule

// File: rtl/ps2_key_event_gen.sv
// PS/2 set-2 scan byte stream to 11-bit ps2_key event word {toggle,pressed,extended,code}.
// Optional typematic-repeat filter enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_key_event_gen
   import ps2_key_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 25_000_000,
   parameter int unsigned PAUSE_SKIP  = 7
) (
   input  logic        clk_sys,
   input  logic        reset_l,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic [10:0] ps2_key,
   output logic        key_strobe,
   output logic [7:0]  drop_cnt
);

   localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam int SW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

   logic [2:0]    state, st_nx;
   logic [SW-1:0] skip_cnt, skip_nx;
   logic [TW-1:0] timer;
   ps2_key_t      key_q;
   logic          ready_q;
   logic          accept, timeout, f0_stage;
   logic          drop_inc, cand, ev_p, ev_e, emit;

   assign accept   = byte_valid & byte_ready;
   assign f0_stage = (state == ST_PFX_F0) || (state == ST_PFX_E0F0);
   assign timeout  = (state != ST_IDLE) && (timer == TW'(TIMEOUT_CYC - 1));
   assign ps2_key  = key_q;

   always_comb begin
      st_nx    = state;
      skip_nx  = skip_cnt;
      drop_inc = 1'b0;
      cand     = 1'b0;
      ev_p     = 1'b0;
      ev_e     = 1'b0;
      if (accept) begin
         if (state == ST_SKIP) begin
            drop_inc = 1'b1;
            skip_nx  = skip_cnt - SW'(1);
            if (skip_cnt <= SW'(1)) st_nx = ST_IDLE;
         end else if (state == ST_IDLE || (f0_stage && is_prefix(byte_data))) begin
            // A prefix arriving after F0 abandons the half-built break.
            drop_inc = f0_stage;
            st_nx    = ST_IDLE;
            case (byte_data)
               BYTE_E0: st_nx = ST_PFX_E0;
               BYTE_F0: st_nx = ST_PFX_F0;
               BYTE_E1: begin
                  st_nx   = ST_SKIP;
                  skip_nx = SW'(PAUSE_SKIP);
               end
               default: begin
                  if (is_reply(byte_data)) drop_inc = 1'b1;
                  else begin
                     cand = 1'b1;
                     ev_p = 1'b1;
                  end
               end
            endcase
         end else if (state == ST_PFX_E0) begin
            st_nx = ST_IDLE;
            if (byte_data == BYTE_F0)          st_nx = ST_PFX_E0F0;
            else if (is_fake_shift(byte_data)) drop_inc = 1'b1;
            else begin
               cand = 1'b1;
               ev_p = 1'b1;
               ev_e = 1'b1;
            end
         end else begin
            st_nx = ST_IDLE;
            if (state == ST_PFX_E0F0 && is_fake_shift(byte_data)) drop_inc = 1'b1;
            else begin
               cand = 1'b1;
               ev_e = (state == ST_PFX_E0F0);
            end
         end
      end else if (timeout) begin
         st_nx    = ST_IDLE;
         drop_inc = 1'b1;
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   logic map_held, map_busy;

   ps2_held_map u_held_map (
      .clk_sys (clk_sys),
      .reset_l (reset_l),
      .addr    ({ev_e, byte_data}),
      .wr_en   (cand),
      .wr_data (ev_p),
      .held    (map_held),
      .busy    (map_busy)
   );

   // Repeated makes of a held key vanish silently; breaks always pass.
   assign emit       = cand & ~(ev_p & map_held);
   assign byte_ready = ready_q & ~map_busy;
`else
   assign emit       = cand;
   assign byte_ready = ready_q;
`endif

   always_ff @(posedge clk_sys or negedge reset_l) begin
      if (!reset_l) begin
         state      <= ST_IDLE;
         skip_cnt   <= '0;
         timer      <= '0;
         key_q      <= '0;
         key_strobe <= 1'b0;
         drop_cnt   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state      <= st_nx;
         skip_cnt   <= skip_nx;
         key_strobe <= emit;
         if (accept || state == ST_IDLE || timeout) timer <= '0;
         else                                       timer <= timer + TW'(1);
         if (emit) begin
            key_q.toggle   <= ~key_q.toggle;
            key_q.pressed  <= ev_p;
            key_q.extended <= ev_e;
            key_q.code     <= byte_data;
         end
         if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`ifdef PS2_REPEAT_FILTER_EN
         ready_q <= ~(accept & cand);
`else
         ready_q <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Self-checking bench for ps2_key_event_gen: directed scenarios plus a random
// byte stream scored against a flag-based behavioural parser.
module tb_ps2_key_event_gen;

   logic        clk_sys = 1'b0;
   logic        reset_l = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic [7:0]  drop_cnt;

   int vec = 0;
   int err = 0;
   int strobe_cnt = 0;

   // reference model state
   logic [10:0] m_key;
   int          m_drop;
   bit          m_e0, m_f0;
   int          m_skip;
   bit [511:0]  m_held;

   ps2_key_event_gen #(.TIMEOUT_CYC(16), .PAUSE_SKIP(7)) dut (
      .clk_sys    (clk_sys),
      .reset_l    (reset_l),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (key_strobe === 1'b1) strobe_cnt++;

   function automatic logic [7:0] sat_drop();
      return (m_drop > 255) ? 8'hFF : 8'(m_drop);
   endfunction

   task automatic model_reset();
      m_key = '0; m_drop = 0; m_e0 = 0; m_f0 = 0; m_skip = 0; m_held = '0;
   endtask

   task automatic model_emit(input bit p, input bit e, input logic [7:0] c, output bit ev);
      ev = 0;
`ifdef PS2_REPEAT_FILTER_EN
      if (p && m_held[{e, c}]) return;
      m_held[{e, c}] = p;
`endif
      m_key = {~m_key[10], p, e, c};
      ev = 1;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit ev);
      ev = 0;
      if (m_skip > 0) begin
         m_skip--; m_drop++;
         return;
      end
      if (m_f0 && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) begin
         m_drop++; m_e0 = 0; m_f0 = 0;
      end
      if (m_f0) begin
         if (m_e0 && (b == 8'h12 || b == 8'h59)) m_drop++;
         else model_emit(0, m_e0, b, ev);
         m_e0 = 0; m_f0 = 0;
      end else if (m_e0) begin
         if (b == 8'hF0) m_f0 = 1;
         else begin
            if (b == 8'h12 || b == 8'h59) m_drop++;
            else model_emit(1, 1, b, ev);
            m_e0 = 0;
         end
      end else begin
         if (b == 8'hE0)      m_e0 = 1;
         else if (b == 8'hF0) m_f0 = 1;
         else if (b == 8'hE1) m_skip = 7;
         else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) m_drop++;
         else model_emit(1, 0, b, ev);
      end
   endtask

   task automatic model_timeout();
      if (m_e0 || m_f0 || m_skip > 0) begin
         m_drop++; m_e0 = 0; m_f0 = 0; m_skip = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      byte_valid = 0;
      reset_l = 0;
      repeat (2) @(negedge clk_sys);
      reset_l = 1;
      model_reset();
   endtask

   // wait (bounded) for ready, present one byte for one accepting edge
   task automatic push_byte(input logic [7:0] b, output bit ok);
      int n;
      @(negedge clk_sys);
      byte_valid = 1; byte_data = b;
      n = 0;
      while (byte_ready !== 1'b1 && n < 2000) begin
         @(negedge clk_sys); n++;
      end
      ok = (n < 2000);
      if (!ok) begin
         vec++; err++;
         $display("FAIL ready_wait byte=%02h: byte_ready stayed %b, required 1", b, byte_ready);
         byte_valid = 0;
         return;
      end
      @(posedge clk_sys); #1;
      byte_valid = 0;
   endtask

   task automatic send_chk(input logic [7:0] b);
      bit ev, ok;
      push_byte(b, ok);
      if (!ok) return;
      model_byte(b, ev);
      vec++;
      if (key_strobe !== ev || ps2_key !== m_key || drop_cnt !== sat_drop()) begin
         err++;
         $display("FAIL byte_%02h: strobe=%b key=%03h drop=%0d, required strobe=%b key=%03h drop=%0d",
                  b, key_strobe, ps2_key, drop_cnt, ev, m_key, sat_drop());
      end
      @(posedge clk_sys); #1;
      vec++;
      if (key_strobe !== 1'b0) begin
         err++;
         $display("FAIL strobe_width after %02h: strobe=%b, required 0", b, key_strobe);
      end
   endtask

   task automatic test_reset();
      reset_l = 0; byte_valid = 0;
      repeat (3) @(negedge clk_sys);
      vec++;
      if (ps2_key !== 11'h000 || key_strobe !== 1'b0 || byte_ready !== 1'b0 || drop_cnt !== 8'h00) begin
         err++;
         $display("FAIL reset_state: key=%03h strobe=%b ready=%b drop=%0d, required 0/0/0/0",
                  ps2_key, key_strobe, byte_ready, drop_cnt);
      end
      reset_l = 1;
      model_reset();
      @(posedge clk_sys); #1;
      vec++;
`ifdef PS2_REPEAT_FILTER_EN
      if (byte_ready !== 1'b0) begin
         err++;
         $display("FAIL ready_during_sweep: ready=%b, required 0", byte_ready);
      end
`else
      if (byte_ready !== 1'b1) begin
         err++;
         $display("FAIL ready_after_release: ready=%b, required 1", byte_ready);
      end
`endif
   endtask

   task automatic test_make_break();
      send_chk(8'h1C);
      vec++;
      if (ps2_key !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
         err++;
         $display("FAIL first_make: key=%03h, required %03h", ps2_key, {1'b1, 1'b1, 1'b0, 8'h1C});
      end
      send_chk(8'hF0);
      send_chk(8'h1C);
      vec++;
      if (ps2_key !== 11'h01C) begin
         err++;
         $display("FAIL first_break: key=%03h, required 01c", ps2_key);
      end
   endtask

   task automatic test_extended();
      int d0;
      send_chk(8'hE0); send_chk(8'h6B);
      send_chk(8'hE0); send_chk(8'hF0); send_chk(8'h6B);
      vec++;
      if (ps2_key[9:0] !== {1'b0, 1'b1, 8'h6B}) begin
         err++;
         $display("FAIL ext_break: key=%03h, required low bits %03h", ps2_key, {1'b0, 1'b1, 8'h6B});
      end
      d0 = m_drop;
      send_chk(8'hE0); send_chk(8'h12);
      vec++;
      if (drop_cnt !== 8'(d0 + 1)) begin
         err++;
         $display("FAIL fake_shift: drop=%0d, required %0d", drop_cnt, d0 + 1);
      end
   endtask

   task automatic test_pause();
      logic [7:0] seq[$];
      int s0, d0;
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      s0 = strobe_cnt; d0 = m_drop;
      foreach (seq[i]) send_chk(seq[i]);
      vec++;
      if (strobe_cnt != s0 || drop_cnt !== 8'(d0 + 7)) begin
         err++;
         $display("FAIL pause_skip: events=%0d drop=%0d, required 0 and %0d", strobe_cnt - s0, drop_cnt, d0 + 7);
      end
      send_chk(8'h29);
      vec++;
      if (ps2_key[9:0] !== {1'b1, 1'b0, 8'h29}) begin
         err++;
         $display("FAIL after_pause: key=%03h, required low bits 229", ps2_key);
      end
   endtask

   task automatic test_replies();
      int s0, d0;
      s0 = strobe_cnt; d0 = m_drop;
      send_chk(8'hAA); send_chk(8'hFA); send_chk(8'hFE);
      vec++;
      if (strobe_cnt != s0 || drop_cnt !== 8'(d0 + 3)) begin
         err++;
         $display("FAIL replies: events=%0d drop=%0d, required 0 and %0d", strobe_cnt - s0, drop_cnt, d0 + 3);
      end
   endtask

   task automatic test_timeout();
      int d0;
      d0 = m_drop;
      send_chk(8'hF0);
      repeat (8) @(posedge clk_sys);
      #1;
      vec++;
      if (drop_cnt !== 8'(d0)) begin
         err++;
         $display("FAIL timeout_early: drop=%0d, required %0d", drop_cnt, d0);
      end
      repeat (10) @(posedge clk_sys);
      #1;
      model_timeout();
      vec++;
      if (drop_cnt !== sat_drop() || drop_cnt !== 8'(d0 + 1)) begin
         err++;
         $display("FAIL timeout_fire: drop=%0d, required %0d", drop_cnt, d0 + 1);
      end
      send_chk(8'h1C);
      vec++;
      if (ps2_key[9:0] !== {1'b1, 1'b0, 8'h1C}) begin
         err++;
         $display("FAIL timeout_then_make: key=%03h, required low bits 21c", ps2_key);
      end
   endtask

   task automatic test_reset_mid();
      send_chk(8'hE0);
      @(negedge clk_sys);
      reset_l = 0;
      #1;
      vec++;
      if (ps2_key !== 11'h000 || key_strobe !== 1'b0 || drop_cnt !== 8'h00 || byte_ready !== 1'b0) begin
         err++;
         $display("FAIL reset_mid: key=%03h strobe=%b drop=%0d ready=%b, required all 0",
                  ps2_key, key_strobe, drop_cnt, byte_ready);
      end
      @(negedge clk_sys);
      reset_l = 1;
      model_reset();
      send_chk(8'h1C);
      vec++;
      if (ps2_key !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
         err++;
         $display("FAIL make_after_reset: key=%03h, required %03h", ps2_key, {1'b1, 1'b1, 1'b0, 8'h1C});
      end
   endtask

   // valid held continuously; the DUT paces the stream with byte_ready
   task automatic run_burst(input logic [7:0] seq[$], output int nev);
      int n;
      bit ev;
      nev = 0;
      foreach (seq[i]) begin
         @(negedge clk_sys);
         byte_valid = 1; byte_data = seq[i];
         n = 0;
         while (byte_ready !== 1'b1 && n < 2000) begin
            @(negedge clk_sys); n++;
         end
         if (n >= 2000) begin
            vec++; err++;
            $display("FAIL burst_ready_wait: byte_ready=%b, required 1", byte_ready);
            break;
         end
         @(posedge clk_sys);
         model_byte(seq[i], ev);
         if (ev) nev++;
      end
      #1 byte_valid = 0;
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq[$];
      int s0, nev;
      seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'h33, 8'h33};
      s0 = strobe_cnt;
      run_burst(seq, nev);
      vec++;
      if (strobe_cnt - s0 != nev || ps2_key !== m_key || drop_cnt !== sat_drop()) begin
         err++;
         $display("FAIL back_to_back: events=%0d key=%03h drop=%0d, required %0d %03h %0d",
                  strobe_cnt - s0, ps2_key, drop_cnt, nev, m_key, sat_drop());
      end
   endtask

   task automatic test_random();
      logic [7:0] replies[8];
      logic [7:0] b;
      int r;
      replies = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 12)      b = 8'hE0;
         else if (r < 24) b = 8'hF0;
         else if (r < 27) b = 8'hE1;
         else if (r < 37) b = replies[$urandom_range(0, 7)];
         else if (r < 45) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
         else if (r < 75) b = 8'($urandom_range(1, 16));
         else             b = 8'($urandom_range(0, 255));
         send_chk(b);
      end
   endtask

   task automatic test_saturate();
      logic [7:0] seq[$];
      int nev;
      do_reset();
      for (int i = 0; i < 260; i++) seq.push_back(8'hAA);
      run_burst(seq, nev);
      vec++;
      if (drop_cnt !== 8'hFF || m_drop != 260) begin
         err++;
         $display("FAIL drop_saturate: drop=%0d, required 255", drop_cnt);
      end
   endtask

`ifdef PS2_REPEAT_FILTER_EN
   task automatic test_repeat_filter();
      logic [7:0] seq[$];
      int s0;
      bit ev, ok, term;
      do_reset();
      seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
      s0 = strobe_cnt;
      foreach (seq[i]) begin
         push_byte(seq[i], ok);
         if (!ok) return;
         model_byte(seq[i], ev);
         term = (seq[i] != 8'hF0);
         vec++;
         if (byte_ready !== !term) begin
            err++;
            $display("FAIL rmw_ready byte %0d: ready=%b, required %b", i, byte_ready, !term);
         end
         @(posedge clk_sys); #1;
         vec++;
         if (byte_ready !== 1'b1) begin
            err++;
            $display("FAIL rmw_ready_back byte %0d: ready=%b, required 1", i, byte_ready);
         end
      end
      repeat (2) @(negedge clk_sys);
      vec++;
      if (strobe_cnt - s0 != 2 || ps2_key !== m_key || drop_cnt !== 8'h00) begin
         err++;
         $display("FAIL repeat_filter: events=%0d key=%03h drop=%0d, required 2 %03h 0",
                  strobe_cnt - s0, ps2_key, drop_cnt, m_key);
      end
   endtask
`endif

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_make_break();
      test_extended();
      test_pause();
      test_replies();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_saturate();
`ifdef PS2_REPEAT_FILTER_EN
      test_repeat_filter();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
